// File: rtl/knock_pkg.sv
// Shared types and helpers for the matrix-inverse capture/hold stage.
// Holds the FSM state encoding, the parameter legality check and the element slice offset.
package knock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } knock_state_e;

    function automatic bit knock_params_ok(input int frame_len, input int cap_cyc,
                                           input int cap_win, input int rel_cyc,
                                           input int cnt_w);
        return (cap_win >= 1) && (cap_cyc >= 0)
            && (cap_cyc + cap_win <= rel_cyc)
            && (rel_cyc < frame_len)
            && ((longint'(1) << cnt_w) >= longint'(frame_len));
    endfunction

    function automatic int elem_lo(input int k, input int data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/knock_frame_cnt.sv
// Free-running frame counter with resync, plus decode of the capture window and release point.
// Decodes are purely combinational from the registered count.
module knock_frame_cnt
    import knock_pkg::*;
#(
    parameter int FRAME_LEN   = 1026,
    parameter int CAPTURE_CYC = 103,
    parameter int CAPTURE_WIN = 1,
    parameter int RELEASE_CYC = 1020,
    parameter int CNT_W       = 11
) (
    input  logic             I_sys_clk,
    input  logic             I_sys_rstn,
    input  logic             I_frame_sync,
    output logic [CNT_W-1:0] O_cnt,
    output logic             O_win_active,
    output logic             O_win_first,
    output logic             O_win_last,
    output logic             O_release
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] WIN_FIRST = CNT_W'(CAPTURE_CYC);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(CAPTURE_CYC + CAPTURE_WIN - 1);
    localparam logic [CNT_W-1:0] REL_CNT   = CNT_W'(RELEASE_CYC);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge I_sys_clk) begin
        if (!I_sys_rstn) begin
            cnt <= '0;
        end else if (I_frame_sync || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign O_cnt        = cnt;
    assign O_win_active = (cnt >= WIN_FIRST) && (cnt <= WIN_LAST);
    assign O_win_first  = (cnt == WIN_FIRST);
    assign O_win_last   = (cnt == WIN_LAST);
    assign O_release    = (cnt == REL_CNT);

endmodule

// File: rtl/knock_mat_inv_hold.sv
// Once-per-frame capture of N_ELEM inverse elements, held stable for the downstream consumer.
// state | meaning
// IDLE  | waiting for the capture window (data may still be held in sticky mode)
// ARMED | inside the window, waiting for upstream valid
// HOLD  | captured; outputs frozen until release or resync
module knock_mat_inv_hold
    import knock_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int N_ELEM      = 4,
    parameter int FRAME_LEN   = 1026,
    parameter int CAPTURE_CYC = 103,
    parameter int CAPTURE_WIN = 1,
    parameter int RELEASE_CYC = 1020,
    parameter int CNT_W       = 11
) (
    input  logic                     I_sys_clk,
    input  logic                     I_sys_rstn,
    input  logic                     I_frame_sync,
    input  logic                     I_sticky,
    input  logic                     I_inv_valid,
    input  logic [N_ELEM*DATA_W-1:0] I_inv_data,
    output logic [N_ELEM*DATA_W-1:0] O_inv_data,
    output logic                     O_inv_valid,
    output logic                     O_inv_new,
    output logic                     O_miss,
    output logic                     O_overrun,
    output logic [CNT_W-1:0]         O_frame_cnt
);

    localparam int BUS_W = N_ELEM * DATA_W;

    if (!knock_params_ok(FRAME_LEN, CAPTURE_CYC, CAPTURE_WIN, RELEASE_CYC, CNT_W)) begin : g_param_check
        $error("knock_mat_inv_hold: illegal frame/window/release parameter set");
    end

    logic             win_active;
    logic             win_first;
    logic             win_last;
    logic             rel_hit;
    logic [CNT_W-1:0] cnt;

    knock_frame_cnt #(
        .FRAME_LEN   (FRAME_LEN),
        .CAPTURE_CYC (CAPTURE_CYC),
        .CAPTURE_WIN (CAPTURE_WIN),
        .RELEASE_CYC (RELEASE_CYC),
        .CNT_W       (CNT_W)
    ) u_frame_cnt (
        .I_sys_clk    (I_sys_clk),
        .I_sys_rstn   (I_sys_rstn),
        .I_frame_sync (I_frame_sync),
        .O_cnt        (cnt),
        .O_win_active (win_active),
        .O_win_first  (win_first),
        .O_win_last   (win_last),
        .O_release    (rel_hit)
    );

    knock_state_e     state_q, state_nxt;
    logic [BUS_W-1:0] data_q, data_nxt;
    logic             valid_q, valid_nxt;
    logic             new_q, new_nxt;
    logic             miss_q, miss_nxt;
    logic             ovr_q, ovr_nxt;
    logic             cap_open;
    logic             capture;

    // IDLE is included so a one-cycle window can arm and capture on the same edge.
    assign cap_open = ((state_q == IDLE) || (state_q == ARMED)) && win_active;
    assign capture  = cap_open && I_inv_valid;

    always_ff @(posedge I_sys_clk) begin
        if (!I_sys_rstn) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            new_q   <= 1'b0;
            miss_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            new_q   <= new_nxt;
            miss_q  <= miss_nxt;
            ovr_q   <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        data_nxt  = data_q;
        valid_nxt = valid_q;
        new_nxt   = 1'b0;
        miss_nxt  = 1'b0;
        ovr_nxt   = ovr_q;

        if (capture) begin
            for (int k = 0; k < N_ELEM; k++) begin
                data_nxt[elem_lo(k, DATA_W) +: DATA_W] = I_inv_data[elem_lo(k, DATA_W) +: DATA_W];
            end
            valid_nxt = 1'b1;
            new_nxt   = 1'b1;
        end

        if ((state_q == HOLD) && win_active && I_inv_valid) begin
            ovr_nxt = 1'b1;
        end

        if (I_frame_sync) begin
            state_nxt = IDLE;
            // Resync acts as an early release; a capture on the same edge still lands.
            if (!capture && (state_q != IDLE) && !I_sticky) begin
                data_nxt  = '0;
                valid_nxt = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        state_nxt = HOLD;
                    end else if (cap_open && win_last) begin
                        miss_nxt = 1'b1;
                    end else if (win_first) begin
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (capture) begin
                        state_nxt = HOLD;
                    end else if (win_last) begin
                        miss_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                HOLD: begin
                    if (rel_hit) begin
                        state_nxt = IDLE;
                        if (!I_sticky) begin
                            data_nxt  = '0;
                            valid_nxt = 1'b0;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign O_inv_data  = data_q;
    assign O_inv_valid = valid_q;
    assign O_inv_new   = new_q;
    assign O_miss      = miss_q;
    assign O_overrun   = ovr_q;
    assign O_frame_cnt = cnt;

endmodule

// File: tb/tb_knock_mat_inv_hold.sv
// Directed bench: a small-parameter instance driven from a vector table, plus two
// full-size instances (window 1 and window 4) exercised with multi-frame sequences.
module tb_knock_mat_inv_hold;

    localparam int BW = 256;
    localparam logic [BW-1:0] D1 = {64'd4, 64'd3, 64'd2, 64'd1};
    localparam logic [BW-1:0] DA = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    localparam logic [BW-1:0] DB = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
    localparam logic [BW-1:0] DC = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
    localparam logic [BW-1:0] DD = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
    localparam logic [BW-1:0] DE = {64'hE3, 64'hE2, 64'hE1, 64'hE0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus for the two full-size instances
    logic          rstn, sync, sticky, vld;
    logic [BW-1:0] din;
    logic [BW-1:0] a_data, b_data;
    logic          a_valid, a_new, a_miss, a_ovr;
    logic          b_valid, b_new, b_miss, b_ovr;
    logic [10:0]   a_cnt, b_cnt;

    // small instance: FRAME_LEN 16, window 3..4, release 12
    logic          s_rstn, s_sync, s_sticky, s_vld;
    logic [15:0]   s_din, s_data;
    logic          s_valid, s_new, s_miss, s_ovr;
    logic [3:0]    s_cnt;

    knock_mat_inv_hold u_a (
        .I_sys_clk(clk), .I_sys_rstn(rstn), .I_frame_sync(sync), .I_sticky(sticky),
        .I_inv_valid(vld), .I_inv_data(din), .O_inv_data(a_data), .O_inv_valid(a_valid),
        .O_inv_new(a_new), .O_miss(a_miss), .O_overrun(a_ovr), .O_frame_cnt(a_cnt)
    );

    knock_mat_inv_hold #(.CAPTURE_WIN(4)) u_b (
        .I_sys_clk(clk), .I_sys_rstn(rstn), .I_frame_sync(sync), .I_sticky(sticky),
        .I_inv_valid(vld), .I_inv_data(din), .O_inv_data(b_data), .O_inv_valid(b_valid),
        .O_inv_new(b_new), .O_miss(b_miss), .O_overrun(b_ovr), .O_frame_cnt(b_cnt)
    );

    knock_mat_inv_hold #(
        .DATA_W(8), .N_ELEM(2), .FRAME_LEN(16), .CAPTURE_CYC(3),
        .CAPTURE_WIN(2), .RELEASE_CYC(12), .CNT_W(4)
    ) u_s (
        .I_sys_clk(clk), .I_sys_rstn(s_rstn), .I_frame_sync(s_sync), .I_sticky(s_sticky),
        .I_inv_valid(s_vld), .I_inv_data(s_din), .O_inv_data(s_data), .O_inv_valid(s_valid),
        .O_inv_new(s_new), .O_miss(s_miss), .O_overrun(s_ovr), .O_frame_cnt(s_cnt)
    );

    int total = 0;
    int bad   = 0;

    // in  = {rstn, sync, sticky, valid}; flg = {valid, new, miss, overrun}
    typedef struct {
        int          n;
        logic [3:0]  in;
        logic [15:0] din;
        int          cnt;
        logic [15:0] data;
        logic [3:0]  flg;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input int n, input logic [3:0] in, input logic [15:0] d,
                                input int c, input logic [15:0] ed, input logic [3:0] f);
        vec_t v;
        v.n = n; v.in = in; v.din = d; v.cnt = c; v.data = ed; v.flg = f;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int t);
        int n;
        n = 0;
        while ((int'(a_cnt) != t) && (n < 2100)) begin
            step();
            n++;
        end
        if (int'(a_cnt) != t) begin
            total++;
            bad++;
            $display("FAIL wait_cnt: cnt %0d never reached %0d", a_cnt, t);
        end
    endtask

    function automatic logic [3:0] a_flg();
        return {a_valid, a_new, a_miss, a_ovr};
    endfunction

    function automatic logic [3:0] b_flg();
        return {b_valid, b_new, b_miss, b_ovr};
    endfunction

    initial begin
        int errs;

        tbl[0]  = mk(1, 4'b0000, 16'h0000, 0,  16'h0000, 4'b0000);
        tbl[1]  = mk(1, 4'b1001, 16'hAAAA, 1,  16'h0000, 4'b0000);
        tbl[2]  = mk(2, 4'b1000, 16'h0000, 3,  16'h0000, 4'b0000);
        tbl[3]  = mk(1, 4'b1000, 16'h0000, 4,  16'h0000, 4'b0000);
        tbl[4]  = mk(1, 4'b1001, 16'h1234, 5,  16'h1234, 4'b1100);
        tbl[5]  = mk(1, 4'b1001, 16'h4321, 6,  16'h1234, 4'b1000);
        tbl[6]  = mk(6, 4'b1000, 16'h0000, 12, 16'h1234, 4'b1000);
        tbl[7]  = mk(1, 4'b1000, 16'h0000, 13, 16'h0000, 4'b0000);
        tbl[8]  = mk(6, 4'b1000, 16'h0000, 3,  16'h0000, 4'b0000);
        tbl[9]  = mk(1, 4'b1001, 16'h5678, 4,  16'h5678, 4'b1100);
        tbl[10] = mk(1, 4'b1001, 16'h8765, 5,  16'h5678, 4'b1001);
        tbl[11] = mk(7, 4'b1010, 16'h0000, 12, 16'h5678, 4'b1001);
        tbl[12] = mk(1, 4'b1010, 16'h0000, 13, 16'h5678, 4'b1001);
        tbl[13] = mk(6, 4'b1010, 16'h0000, 3,  16'h5678, 4'b1001);
        tbl[14] = mk(1, 4'b1010, 16'h0000, 4,  16'h5678, 4'b1001);
        tbl[15] = mk(1, 4'b1010, 16'h0000, 5,  16'h5678, 4'b1011);
        tbl[16] = mk(1, 4'b1010, 16'h0000, 6,  16'h5678, 4'b1001);
        tbl[17] = mk(1, 4'b1110, 16'h0000, 0,  16'h5678, 4'b1001);
        tbl[18] = mk(3, 4'b1010, 16'h0000, 3,  16'h5678, 4'b1001);
        tbl[19] = mk(1, 4'b1111, 16'h9ABC, 0,  16'h9ABC, 4'b1101);
        tbl[20] = mk(3, 4'b1000, 16'h0000, 3,  16'h9ABC, 4'b1001);
        tbl[21] = mk(1, 4'b1000, 16'h0000, 4,  16'h9ABC, 4'b1001);
        tbl[22] = mk(1, 4'b1100, 16'h0000, 0,  16'h0000, 4'b0001);
        tbl[23] = mk(1, 4'b0111, 16'hFFFF, 0,  16'h0000, 4'b0000);
        tbl[24] = mk(3, 4'b1001, 16'h1111, 3,  16'h0000, 4'b0000);
        tbl[25] = mk(1, 4'b1001, 16'h1111, 4,  16'h1111, 4'b1100);

        rstn = 1'b0; sync = 1'b0; sticky = 1'b0; vld = 1'b0; din = '0;
        s_rstn = 1'b0; s_sync = 1'b0; s_sticky = 1'b0; s_vld = 1'b0; s_din = '0;

        for (int i = 0; i < 26; i++) begin
            {s_rstn, s_sync, s_sticky, s_vld} = tbl[i].in;
            s_din = tbl[i].din;
            repeat (tbl[i].n) step();
            chk($sformatf("vec%0d cnt", i),  BW'(s_cnt), BW'(tbl[i].cnt));
            chk($sformatf("vec%0d data", i), BW'(s_data), BW'(tbl[i].data));
            chk($sformatf("vec%0d flags", i), BW'({s_valid, s_new, s_miss, s_ovr}), BW'(tbl[i].flg));
        end

        // reset state of the full-size instance
        rstn = 1'b0; vld = 1'b1; din = D1;
        step();
        chk("rst cnt", BW'(a_cnt), BW'(0));
        chk("rst data", a_data, '0);
        chk("rst flags", BW'(a_flg()), BW'(4'b0000));

        // capture at 103, visible at 104, held to 1020, cleared at 1021
        rstn = 1'b1;
        wait_cnt(103);
        chk("t1 pre flags", BW'(a_flg()), BW'(4'b0000));
        step();
        chk("t1 cap data", a_data, D1);
        chk("t1 cap flags", BW'(a_flg()), BW'(4'b1100));
        step();
        chk("t1 new drop", BW'(a_flg()), BW'(4'b1000));
        errs = 0;
        for (int c = 105; c <= 1020; c++) begin
            if ((a_data !== D1) || (a_valid !== 1'b1)) errs++;
            step();
        end
        chk("t1 hold errs", BW'(errs), BW'(0));
        chk("t1 rel cnt", BW'(a_cnt), BW'(1021));
        chk("t1 rel data", a_data, '0);
        chk("t1 rel flags", BW'(a_flg()), BW'(4'b0000));

        // miss with mode 0
        vld = 1'b0;
        wait_cnt(104);
        chk("t3 miss flags", BW'(a_flg()), BW'(4'b0010));
        step();
        chk("t3 miss drop", BW'(a_flg()), BW'(4'b0000));
        errs = 0;
        for (int c = 105; c <= 1025; c++) begin
            if (a_valid !== 1'b0) errs++;
            step();
        end
        chk("t3 valid errs", BW'(errs), BW'(0));

        // sticky: capture A, miss keeps A, capture B
        sticky = 1'b1; vld = 1'b1; din = DA;
        wait_cnt(104);
        chk("t4 capA data", a_data, DA);
        chk("t4 capA flags", BW'(a_flg()), BW'(4'b1100));
        vld = 1'b0;
        wait_cnt(1021);
        chk("t4 rel data", a_data, DA);
        chk("t4 rel flags", BW'(a_flg()), BW'(4'b1000));
        wait_cnt(104);
        chk("t4 miss data", a_data, DA);
        chk("t4 miss flags", BW'(a_flg()), BW'(4'b1010));
        step();
        vld = 1'b1; din = DB;
        wait_cnt(104);
        chk("t4 capB data", a_data, DB);
        chk("t4 capB flags", BW'(a_flg()), BW'(4'b1100));

        // resync in HOLD with mode 0, then recapture
        sticky = 1'b0; din = DC;
        wait_cnt(500);
        chk("t5 hold data", a_data, DB);
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("t5 sync cnt", BW'(a_cnt), BW'(0));
        chk("t5 sync data", a_data, '0);
        chk("t5 sync flags", BW'(a_flg()), BW'(4'b0000));
        wait_cnt(104);
        chk("t5 recap data", a_data, DC);
        chk("t5 recap flags", BW'(a_flg()), BW'(4'b1100));

        // reset mid-HOLD; B has an overrun pending from constant valid
        wait_cnt(600);
        chk("t6 b ovr pre", BW'(b_ovr), BW'(1'b1));
        rstn = 1'b0;
        step();
        chk("t6 rst cnt", BW'(a_cnt), BW'(0));
        chk("t6 rst data", a_data, '0);
        chk("t6 rst flags", BW'(a_flg()), BW'(4'b0000));
        chk("t6 b rst flags", BW'(b_flg()), BW'(4'b0000));
        chk("t6 b rst data", b_data, '0);
        rstn = 1'b1;
        step();
        chk("t6 restart cnt", BW'(a_cnt), BW'(1));

        // window of 4 on B: valid at 105 latches at 106, overrun at 107
        vld = 1'b0; din = '0;
        wait_cnt(105);
        chk("t2 pre flags", BW'(b_flg()), BW'(4'b0000));
        vld = 1'b1; din = DD;
        step();
        chk("t2 cap data", b_data, DD);
        chk("t2 cap flags", BW'(b_flg()), BW'(4'b1100));
        din = DE;
        step();
        chk("t2 ovr cnt", BW'(b_cnt), BW'(107));
        chk("t2 ovr data", b_data, DD);
        chk("t2 ovr flags", BW'(b_flg()), BW'(4'b1001));
        vld = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
